mdio_sched: RTL and testbench

- Sequences and shares the single PHY management engine (mdio_if) between two requesters:
  - the UART register interface (host);
  - an internal link-status poller that periodically reads the PHY status register.
- Arbitrates between them, holds one transaction outstanding at a time, and enforces a timeout.
- Publishes latched PHY status (link_up, last status word) for LEDs and the register map.
- Sits between reg_intf and mdio_if in the fpga top level, in the 125 MHz clk_int domain.

---
 rtl/mdio_pkg.sv | 25 ++
 rtl/mdio_poll_timer.sv | 39 +++
 rtl/mdio_sched.sv | 163 ++++++++++++++++
 tb/tb_mdio_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the PHY management scheduler.
// FSM states, grant encoding, BMSR address and the read data returned on timeout.
package mdio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    typedef enum logic {
        GNT_HOST,
        GNT_POLL
    } grant_t;

    typedef struct packed {
        logic        write;
        logic [4:0]  addr;
        logic [15:0] wdata;
    } mdio_req_t;

    localparam logic [4:0]  BMSR_ADDR     = 5'd1;
    localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

endpackage

// File: rtl/mdio_poll_timer.sv
// Free-running poll period counter that raises poll_pending once per period.
// Disabling clears both counter and pending; the scheduler clears pending once the poll is served.
module mdio_poll_timer
    import mdio_pkg::*;
#(
    parameter int POLL_PERIOD = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic poll_enable,
    input  logic poll_clr,
    output logic poll_pending
);

    localparam int CW = $clog2(POLL_PERIOD);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(POLL_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            poll_pending <= 1'b0;
        end else if (!poll_enable) begin
            cnt          <= '0;
            poll_pending <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            // A fresh period wins over the clear of the poll just served.
            if (wrap)
                poll_pending <= 1'b1;
            else if (poll_clr)
                poll_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mdio_sched.sv
// Shares one mdio_if engine between the host register path and a periodic BMSR poller.
// One transaction outstanding, round-robin on contention, per-transaction timeout.
module mdio_sched
    import mdio_pkg::*;
#(
    parameter int         POLL_PERIOD = 12500000,
    parameter logic [4:0] POLL_ADDR   = BMSR_ADDR,
    parameter int         LINK_BIT    = 2,
    parameter int         TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_valid,
    input  logic        host_write,
    input  logic [4:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_done,
    output logic [15:0] host_rdata,
    output logic        host_err,
    input  logic        poll_enable,
    output logic        m_valid,
    output logic        m_write,
    output logic [4:0]  m_addr,
    output logic [15:0] m_wdata,
    input  logic        m_done,
    input  logic [15:0] m_rdata,
    output logic        link_up,
    output logic [15:0] phy_status,
    output logic [7:0]  timeout_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t      state, state_nxt;
    grant_t      cur_gnt, last_gnt;
    mdio_req_t   req;
    logic [15:0] rdata_q;
    logic        err_q;
    logic [TW-1:0] tmo;
    logic        tmo_hit;
    logic        poll_pending, poll_clr;
    logic        host_req, gnt_host, gnt_poll;

    mdio_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .poll_enable  (poll_enable),
        .poll_clr     (poll_clr),
        .poll_pending (poll_pending)
    );

    // The host still holds host_valid in its host_done cycle; that is not a new request.
    assign host_req = host_valid & ~host_done;
    assign tmo_hit  = (tmo == TW'(TIMEOUT - 1));

    assign m_write = req.write;
    assign m_addr  = req.addr;
    assign m_wdata = req.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt_host  = 1'b0;
        gnt_poll  = 1'b0;
        poll_clr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (host_req && poll_pending) begin
                    if (last_gnt == GNT_POLL) gnt_host = 1'b1;
                    else                      gnt_poll = 1'b1;
                end else if (host_req) begin
                    gnt_host = 1'b1;
                end else if (poll_pending) begin
                    gnt_poll = 1'b1;
                end
                if (gnt_host || gnt_poll)
                    state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (m_done || tmo_hit)
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                poll_clr  = (cur_gnt == GNT_POLL);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req         <= '0;
            m_valid     <= 1'b0;
            cur_gnt     <= GNT_POLL;
            last_gnt    <= GNT_POLL;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo         <= '0;
            host_done   <= 1'b0;
            host_rdata  <= '0;
            host_err    <= 1'b0;
            link_up     <= 1'b0;
            phy_status  <= '0;
            timeout_cnt <= '0;
        end else begin
            host_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tmo <= '0;
                    if (gnt_host) begin
                        req      <= '{write: host_write, addr: host_addr, wdata: host_wdata};
                        cur_gnt  <= GNT_HOST;
                        last_gnt <= GNT_HOST;
                        m_valid  <= 1'b1;
                    end else if (gnt_poll) begin
                        req      <= '{write: 1'b0, addr: POLL_ADDR, wdata: 16'h0000};
                        cur_gnt  <= GNT_POLL;
                        last_gnt <= GNT_POLL;
                        m_valid  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (m_done) begin
                        rdata_q <= m_rdata;
                        err_q   <= 1'b0;
                        m_valid <= 1'b0;
                    end else if (tmo_hit) begin
                        rdata_q <= TIMEOUT_RDATA;
                        err_q   <= 1'b1;
                        m_valid <= 1'b0;
                        if (timeout_cnt != 8'hFF)
                            timeout_cnt <= timeout_cnt + 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (cur_gnt == GNT_HOST) begin
                        host_done  <= 1'b1;
                        host_rdata <= rdata_q;
                        host_err   <= err_q;
                    end else if (err_q) begin
                        link_up <= 1'b0;
                    end else begin
                        phy_status <= rdata_q;
                        link_up    <= rdata_q[LINK_BIT];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_sched.sv
// Scoreboard bench for mdio_sched: expected mdio requests and host responses are queued by the
// stimulus; a PHY-engine model and a host-response monitor pop and compare.
module tb_mdio_sched;
    import mdio_pkg::*;

    localparam int PP = 100;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_valid = 1'b0;
    logic        host_write = 1'b0;
    logic [4:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        host_done;
    logic [15:0] host_rdata;
    logic        host_err;
    logic        poll_enable = 1'b0;
    logic        m_valid, m_write;
    logic [4:0]  m_addr;
    logic [15:0] m_wdata;
    logic        m_done = 1'b0;
    logic [15:0] m_rdata = '0;
    logic        link_up;
    logic [15:0] phy_status;
    logic [7:0]  timeout_cnt;

    always #5 clk = ~clk;

    mdio_sched #(
        .POLL_PERIOD (PP),
        .POLL_ADDR   (5'd1),
        .LINK_BIT    (2),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_valid  (host_valid),
        .host_write  (host_write),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_done   (host_done),
        .host_rdata  (host_rdata),
        .host_err    (host_err),
        .poll_enable (poll_enable),
        .m_valid     (m_valid),
        .m_write     (m_write),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_done      (m_done),
        .m_rdata     (m_rdata),
        .link_up     (link_up),
        .phy_status  (phy_status),
        .timeout_cnt (timeout_cnt)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        bit          lat;
    } rsp_t;

    rsp_t        resp_q[$];
    logic [21:0] req_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // PHY model controls (written by stimulus) and observations (written by model).
    bit          respond = 1'b1;
    int          resp_delay = 10;
    logic [15:0] resp_data = '0;
    int          stray_cnt = 0;
    int          ntxn = 0;
    int          last_start = 0;
    int          prev_start = 0;
    int          mv_len = 0;
    int          done_cyc = 0;
    int          hdone_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_loop();
        int          wait_n = 0;
        bit          busy_m = 1'b0;
        int          stray_done = 0;
        logic [21:0] exp;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (!m_valid) begin
                if (busy_m) mv_len = wait_n + 1;
                busy_m = 1'b0;
                if (stray_cnt != stray_done) begin
                    m_done  = 1'b1;
                    m_rdata = 16'hDEAD;
                    stray_done++;
                end
            end else begin
                if (!busy_m) begin
                    busy_m     = 1'b1;
                    wait_n     = 0;
                    ntxn++;
                    prev_start = last_start;
                    last_start = cyc;
                    exp = (req_q.size() != 0) ? req_q.pop_front() : {1'b0, 5'd1, 16'h0000};
                    chk("mdio_req", 32'({m_write, m_addr, m_wdata}), 32'(exp));
                end else begin
                    wait_n++;
                end
                if (respond && wait_n == resp_delay - 1) begin
                    m_done   = 1'b1;
                    m_rdata  = resp_data;
                    done_cyc = cyc;
                end
            end
        end
    endtask

    task automatic monitor_loop();
        rsp_t r;
        forever begin
            @(negedge clk);
            if (host_done) begin
                hdone_n++;
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL host_done_unexpected: got host_done=1 required 0");
                end else begin
                    r = resp_q.pop_front();
                    chk("host_rdata", 32'(host_rdata), 32'(r.rdata));
                    chk("host_err", 32'(host_err), 32'(r.err));
                    if (r.lat) chk("host_latency", cyc - done_cyc, 2);
                end
            end
        end
    endtask

    task automatic push_req(input logic w, input logic [4:0] a, input logic [15:0] d);
        req_q.push_back({w, a, d});
    endtask

    task automatic host_start(input logic w, input logic [4:0] a, input logic [15:0] d,
                              input logic [15:0] exp_rd, input logic exp_err, input bit lat);
        rsp_t r;
        r.rdata = exp_rd;
        r.err   = exp_err;
        r.lat   = lat;
        resp_q.push_back(r);
        host_write = w;
        host_addr  = a;
        host_wdata = d;
        host_valid = 1'b1;
    endtask

    task automatic host_wait();
        int k = 0;
        bit got = 1'b0;
        while (!got && k < 400) begin
            @(negedge clk);
            got = host_done;
            k++;
        end
        host_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL host_wait: got no host_done in %0d cycles required one", k);
        end
    endtask

    task automatic wait_txn(input int target, input int bound);
        int k = 0;
        while (ntxn < target && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("wait_txn", 32'(ntxn >= target), 32'd1);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int n0, c0, r0, hd0;
        fork
            model_loop();
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_host_done", 32'(host_done), 0);
        chk("rst_host_rdata", 32'(host_rdata), 0);
        chk("rst_host_err", 32'(host_err), 0);
        chk("rst_link_up", 32'(link_up), 0);
        chk("rst_phy_status", 32'(phy_status), 0);
        chk("rst_timeout_cnt", 32'(timeout_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention straight after reset: last grant is POLL, so HOST wins; pending survives.
        respond = 1'b1; resp_delay = 10; resp_data = 16'h1230;
        c0 = cyc;
        poll_enable = 1'b1;
        wait_until(c0 + PP);
        n0 = ntxn;
        push_req(1'b0, 5'd4, 16'h0);
        push_req(1'b0, 5'd1, 16'h0);
        host_start(1'b0, 5'd4, 16'h0, 16'h1230, 1'b0, 1'b1);
        host_wait();
        chk("arbA_host_wait_txns", ntxn - n0, 1);
        wait_txn(n0 + 2, 40);
        repeat (15) @(negedge clk);
        poll_enable = 1'b0;
        chk("arbA_phy_status", 32'(phy_status), 32'h1230);
        chk("arbA_link_up", 32'(link_up), 0);

        // Host write leaves last grant = HOST; then two contended rounds each go POLL then HOST.
        push_req(1'b1, 5'd3, 16'hA5A5);
        host_start(1'b1, 5'd3, 16'hA5A5, 16'h1230, 1'b0, 1'b1);
        host_wait();
        repeat (3) @(negedge clk);
        c0 = cyc;
        poll_enable = 1'b1;
        wait_until(c0 + PP);
        n0 = ntxn;
        push_req(1'b0, 5'd1, 16'h0);
        push_req(1'b0, 5'd5, 16'h0);
        host_start(1'b0, 5'd5, 16'h0, 16'h1230, 1'b0, 1'b1);
        host_wait();
        chk("arbB1_host_wait_txns", ntxn - n0, 2);
        wait_until(c0 + 2 * PP);
        n0 = ntxn;
        push_req(1'b0, 5'd1, 16'h0);
        push_req(1'b0, 5'd6, 16'h0);
        host_start(1'b0, 5'd6, 16'h0, 16'h1230, 1'b0, 1'b1);
        host_wait();
        chk("arbB2_host_wait_txns", ntxn - n0, 2);
        poll_enable = 1'b0;
        repeat (5) @(negedge clk);

        // Plain host read, 40-cycle engine latency.
        resp_delay = 40; resp_data = 16'h4F51;
        push_req(1'b0, 5'd2, 16'h0);
        r0 = cyc;
        n0 = ntxn;
        host_start(1'b0, 5'd2, 16'h0, 16'h4F51, 1'b0, 1'b1);
        host_wait();
        chk("rd_m_valid_start", last_start - r0, 1);
        chk("rd_m_valid_len", mv_len, 40);

        // Stray m_done while idle must be ignored.
        n0 = ntxn;
        stray_cnt++;
        repeat (5) @(negedge clk);
        chk("stray_ntxn", ntxn - n0, 0);
        chk("stray_phy_status", 32'(phy_status), 32'h1230);

        // Periodic polling.
        resp_delay = 5; resp_data = 16'h796D;
        n0 = ntxn;
        poll_enable = 1'b1;
        wait_txn(n0 + 1, 150);
        repeat (10) @(negedge clk);
        chk("poll_link_up", 32'(link_up), 1);
        chk("poll_phy_status", 32'(phy_status), 32'h796D);
        wait_txn(n0 + 2, 150);
        chk("poll_interval", last_start - prev_start, PP);
        repeat (10) @(negedge clk);
        poll_enable = 1'b0;

        // Host timeout.
        respond = 1'b0;
        push_req(1'b0, 5'd7, 16'h0);
        host_start(1'b0, 5'd7, 16'h0, 16'hFFFF, 1'b1, 1'b0);
        host_wait();
        chk("to_m_valid_len", mv_len, TO);
        chk("to_timeout_cnt", 32'(timeout_cnt), 1);

        // Poll timeouts: link_up drops, phy_status holds, counter saturates.
        n0 = ntxn;
        poll_enable = 1'b1;
        wait_txn(n0 + 1, 150);
        repeat (55) @(negedge clk);
        chk("pto_link_up", 32'(link_up), 0);
        chk("pto_phy_status", 32'(phy_status), 32'h796D);
        chk("pto_cnt_2", 32'(timeout_cnt), 2);
        wait_txn(n0 + 200, 200 * PP + 200);
        repeat (55) @(negedge clk);
        chk("pto_cnt_201", 32'(timeout_cnt), 201);
        wait_txn(n0 + 300, 100 * PP + 200);
        repeat (55) @(negedge clk);
        chk("pto_cnt_sat", 32'(timeout_cnt), 255);
        poll_enable = 1'b0;
        repeat (5) @(negedge clk);

        // Reset in the middle of a host transaction.
        push_req(1'b0, 5'd9, 16'h0);
        host_start(1'b0, 5'd9, 16'h0, 16'hFFFF, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        hd0 = hdone_n;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 0);
        host_valid = 1'b0;
        resp_q.delete();
        req_q.delete();
        repeat (3) @(negedge clk);
        chk("midrst_no_done", hdone_n - hd0, 0);
        chk("midrst_timeout_cnt", 32'(timeout_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);
        respond = 1'b1; resp_delay = 5; resp_data = 16'h0BAD;
        push_req(1'b1, 5'd0, 16'h8000);
        host_start(1'b1, 5'd0, 16'h8000, 16'h0BAD, 1'b0, 1'b1);
        host_wait();
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
